// File: rtl/uart_rx_pkg.sv
// Shared types and frame-index constants for the UART receive path.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } par_typ_t;

    localparam int START_IDX      = 0;
    localparam int DATA_FIRST_IDX = 1;

    function automatic int par_idx(input int data_width);
        return data_width + 1;
    endfunction

    function automatic int stop_idx(input int data_width, input logic par_en);
        return par_en ? data_width + 2 : data_width + 1;
    endfunction

endpackage

// File: rtl/uart_rx_deser.sv
// Receive shift register (LSB first on the line) and expected-parity generation.
module uart_rx_deser
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  shift_en,
    input  logic                  bit_in,
    input  logic                  par_typ,
    output logic [DATA_WIDTH-1:0] shreg,
    output logic                  par_exp
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
        end else if (clear) begin
            shreg <= '0;
        end else if (shift_en) begin
            shreg <= {bit_in, shreg[DATA_WIDTH-1:1]};
        end
    end

    assign par_exp = (^shreg) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame sequencer: start detect, data/parity/stop stepping on
// bit-end events, error flags and the one-cycle data_valid strobe.
//
// state  | meaning
// IDLE   | line idle, counters held, waiting for RX_IN low
// START  | bit 0, confirm start bit is really low at mid-bit
// DATA   | bits 1..DATA_WIDTH, shift sampled bits in
// PARITY | parity bit, compare against computed parity
// STOP   | stop bit, check it and publish the byte
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 5,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic [BIT_CNT_W-1:0]  bit_cnt,
    input  logic                  sampled_bit,
    output logic                  cnt_en,
    output logic                  data_samp_en,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam logic [BIT_CNT_W-1:0] IDX_START      = BIT_CNT_W'(START_IDX);
    localparam logic [BIT_CNT_W-1:0] IDX_DATA_FIRST = BIT_CNT_W'(DATA_FIRST_IDX);
    localparam logic [BIT_CNT_W-1:0] IDX_DATA_LAST  = BIT_CNT_W'(DATA_WIDTH);
    localparam logic [BIT_CNT_W-1:0] IDX_PAR        = BIT_CNT_W'(par_idx(DATA_WIDTH));
    localparam logic [BIT_CNT_W-1:0] IDX_STOP_NOPAR = BIT_CNT_W'(stop_idx(DATA_WIDTH, 1'b0));
    localparam logic [BIT_CNT_W-1:0] IDX_STOP_PAR   = BIT_CNT_W'(stop_idx(DATA_WIDTH, 1'b1));

    rx_state_t                 state, state_nxt;
    logic                      run;
    logic [PRESCALE_W-1:0]     prescale_q;
    logic                      par_en_q, par_typ_q;
    logic                      bit_end, start_det, shift_en, par_upd, stop_upd;
    logic [BIT_CNT_W-1:0]      idx_stop;
    logic [DATA_WIDTH-1:0]     shreg;
    logic                      par_exp;

    assign cnt_en       = run;
    assign data_samp_en = run;
    assign bit_end      = run & (edge_cnt == prescale_q - PRESCALE_W'(1));
    assign idx_stop     = par_en_q ? IDX_STOP_PAR : IDX_STOP_NOPAR;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Any bit index that does not match the current state drops back to IDLE.
    always_comb begin
        state_nxt = state;
        start_det = 1'b0;
        shift_en  = 1'b0;
        par_upd   = 1'b0;
        stop_upd  = 1'b0;
        case (state)
            IDLE: begin
                if (!RX_IN) begin
                    state_nxt = START;
                    start_det = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    if (bit_cnt == IDX_START && !sampled_bit) state_nxt = DATA;
                    else                                      state_nxt = IDLE;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt >= IDX_DATA_FIRST && bit_cnt <= IDX_DATA_LAST) begin
                        shift_en = 1'b1;
                        if (bit_cnt == IDX_DATA_LAST) state_nxt = par_en_q ? PARITY : STOP;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    if (bit_cnt == IDX_PAR) begin
                        par_upd   = 1'b1;
                        state_nxt = STOP;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    stop_upd  = (bit_cnt == idx_stop);
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run        <= 1'b0;
            prescale_q <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            p_data     <= '0;
            data_valid <= 1'b0;
        end else begin
            run        <= (state_nxt != IDLE);
            data_valid <= 1'b0;
            if (start_det) begin
                prescale_q <= prescale;
                par_en_q   <= par_en;
                par_typ_q  <= par_typ;
                par_err    <= 1'b0;
                stp_err    <= 1'b0;
            end
            if (par_upd) par_err <= (sampled_bit != par_exp);
            if (stop_upd) begin
                stp_err <= ~sampled_bit;
                if (!par_err && sampled_bit) begin
                    p_data     <= shreg;
                    data_valid <= 1'b1;
                end
            end
        end
    end

    uart_rx_deser #(.DATA_WIDTH(DATA_WIDTH)) u_deser (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_det),
        .shift_en (shift_en),
        .bit_in   (sampled_bit),
        .par_typ  (par_typ_q),
        .shreg    (shreg),
        .par_exp  (par_exp)
    );

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm with behavioural edge/bit counter and majority sampler.
module tb_uart_rx_fsm;
    localparam int DW = 8;
    localparam int PW = 5;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          RX_IN = 1'b1;
    logic [PW-1:0] prescale = 5'd8;
    logic          par_en = 1'b0;
    logic          par_typ = 1'b0;
    logic [PW-1:0] edge_cnt = '0;
    logic [BW-1:0] bit_cnt = '0;
    logic          sampled_bit = 1'b0;
    logic          cnt_en, data_samp_en, data_valid, par_err, stp_err;
    logic [DW-1:0] p_data;

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            last_strobe_cyc = 0;
    int            t0;
    logic [7:0]    exp_q[$];
    logic [7:0]    exp_b;
    logic          prev_valid = 1'b0;
    logic [1:0]    votes = '0;
    logic [PW-1:0] half;

    uart_rx_fsm dut (
        .clk          (clk),
        .rst          (rst),
        .RX_IN        (RX_IN),
        .prescale     (prescale),
        .par_en       (par_en),
        .par_typ      (par_typ),
        .edge_cnt     (edge_cnt),
        .bit_cnt      (bit_cnt),
        .sampled_bit  (sampled_bit),
        .cnt_en       (cnt_en),
        .data_samp_en (data_samp_en),
        .p_data       (p_data),
        .data_valid   (data_valid),
        .par_err      (par_err),
        .stp_err      (stp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!cnt_en) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (edge_cnt == prescale - 5'd1) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
        end else begin
            edge_cnt <= edge_cnt + 5'd1;
        end
    end

    assign half = prescale >> 1;

    always @(posedge clk) begin
        if (data_samp_en) begin
            if (edge_cnt == half - 5'd1) votes[0] <= RX_IN;
            if (edge_cnt == half)        votes[1] <= RX_IN;
            if (edge_cnt == half + 5'd1)
                sampled_bit <= (votes[0] & votes[1]) | (votes[0] & RX_IN) | (votes[1] & RX_IN);
        end
    end

    // Scoreboard: every strobe must match the oldest expected byte.
    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            last_strobe_cyc = cyc;
            total++;
            if (prev_valid === 1'b1) begin
                bad++;
                $display("FAIL strobe_width: data_valid high again, required single-cycle pulse");
            end else if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe: p_data=%h, required no strobe", p_data);
            end else begin
                exp_b = exp_q.pop_front();
                if (p_data !== exp_b) begin
                    bad++;
                    $display("FAIL strobe_data: p_data=%h required %h", p_data, exp_b);
                end
            end
        end
        prev_valid = data_valid;
    end

    task automatic send_frame(input logic [7:0] d, input int p, input logic pe,
                              input logic pt, input logic flip_par, input logic stop_v);
        prescale = PW'(p);
        par_en   = pe;
        par_typ  = pt;
        RX_IN    = 1'b0;
        repeat (p) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX_IN = d[i];
            repeat (p) @(negedge clk);
        end
        if (pe) begin
            RX_IN = (^d) ^ pt ^ flip_par;
            repeat (p) @(negedge clk);
        end
        RX_IN = stop_v;
        repeat (p) @(negedge clk);
        RX_IN = 1'b1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        RX_IN = 1'b0;
        #2 rst = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if ({cnt_en, data_samp_en, data_valid, par_err, stp_err, p_data} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %b, required all zero",
                     {cnt_en, data_samp_en, data_valid, par_err, stp_err, p_data});
        end
        RX_IN = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (cnt_en !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: cnt_en=%b required 0", cnt_en);
        end
    endtask

    task automatic test_basic();
        @(negedge clk);
        t0 = cyc;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL basic_strobe: pending=%0d required 0", exp_q.size());
        end
        total++;
        if (last_strobe_cyc - t0 < 80 || last_strobe_cyc - t0 > 82) begin
            bad++;
            $display("FAIL basic_latency: %0d cycles required 80..82", last_strobe_cyc - t0);
        end
        total++;
        if (p_data !== 8'hA5) begin
            bad++;
            $display("FAIL basic_pdata: %h required a5", p_data);
        end
        total++;
        if ({par_err, stp_err} !== 2'b00) begin
            bad++;
            $display("FAIL basic_errs: %b required 00", {par_err, stp_err});
        end
        total++;
        if ({cnt_en, data_samp_en} !== 2'b00) begin
            bad++;
            $display("FAIL basic_cnt_off: %b required 00", {cnt_en, data_samp_en});
        end
    endtask

    task automatic test_parity();
        @(negedge clk);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0 || p_data !== 8'h3C) begin
            bad++;
            $display("FAIL parity_good: pending=%0d p_data=%h required 0/3c", exp_q.size(), p_data);
        end
        total++;
        if ({par_err, stp_err} !== 2'b00) begin
            bad++;
            $display("FAIL parity_good_errs: %b required 00", {par_err, stp_err});
        end
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        total++;
        if (par_err !== 1'b1) begin
            bad++;
            $display("FAIL parity_bad_flag: par_err=%b required 1", par_err);
        end
        total++;
        if (stp_err !== 1'b0) begin
            bad++;
            $display("FAIL parity_bad_stp: stp_err=%b required 0", stp_err);
        end
        total++;
        if (p_data !== 8'h3C) begin
            bad++;
            $display("FAIL parity_bad_hold: p_data=%h required 3c", p_data);
        end
    endtask

    task automatic test_glitch();
        @(negedge clk);
        prescale = 5'd8;
        par_en   = 1'b0;
        RX_IN    = 1'b0;
        repeat (3) @(negedge clk);
        RX_IN = 1'b1;
        total++;
        if (cnt_en !== 1'b1) begin
            bad++;
            $display("FAIL glitch_started: cnt_en=%b required 1", cnt_en);
        end
        repeat (8) @(negedge clk);
        total++;
        if ({cnt_en, data_samp_en} !== 2'b00) begin
            bad++;
            $display("FAIL glitch_idle: %b required 00", {cnt_en, data_samp_en});
        end
        total++;
        if ({par_err, stp_err} !== 2'b00) begin
            bad++;
            $display("FAIL glitch_errs: %b required 00", {par_err, stp_err});
        end
        total++;
        if (p_data !== 8'h3C) begin
            bad++;
            $display("FAIL glitch_hold: p_data=%h required 3c", p_data);
        end
    endtask

    task automatic test_stop_err();
        @(negedge clk);
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        total++;
        if ({par_err, stp_err} !== 2'b01) begin
            bad++;
            $display("FAIL stop_flag: par/stp=%b required 01", {par_err, stp_err});
        end
        total++;
        if (p_data !== 8'h3C || cnt_en !== 1'b0) begin
            bad++;
            $display("FAIL stop_hold: p_data=%h cnt_en=%b required 3c/0", p_data, cnt_en);
        end
        exp_q.push_back(8'h42);
        fork
            send_frame(8'h42, 8, 1'b0, 1'b0, 1'b0, 1'b1);
            begin
                repeat (4) @(negedge clk);
                total++;
                if (stp_err !== 1'b0) begin
                    bad++;
                    $display("FAIL stop_clear: stp_err=%b required 0", stp_err);
                end
            end
        join
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0 || p_data !== 8'h42) begin
            bad++;
            $display("FAIL stop_next: pending=%0d p_data=%h required 0/42", exp_q.size(), p_data);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        send_frame(8'h55, 16, 1'b1, 1'b1, 1'b0, 1'b1);
        send_frame(8'hAA, 16, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_strobes: pending=%0d required 0", exp_q.size());
        end
        total++;
        if ({par_err, stp_err} !== 2'b00) begin
            bad++;
            $display("FAIL b2b_errs: %b required 00", {par_err, stp_err});
        end
        total++;
        if (p_data !== 8'hAA) begin
            bad++;
            $display("FAIL b2b_last: p_data=%h required aa", p_data);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        fork
            send_frame(8'h99, 8, 1'b0, 1'b0, 1'b0, 1'b1);
            begin
                repeat (43) @(negedge clk);
                rst = 1'b0;
                #1;
                total++;
                if ({cnt_en, data_samp_en, data_valid, par_err, stp_err, p_data} !== '0) begin
                    bad++;
                    $display("FAIL reset_mid: got %b, required all zero",
                             {cnt_en, data_samp_en, data_valid, par_err, stp_err, p_data});
                end
            end
        join
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (cnt_en !== 1'b0 || p_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid_after: cnt_en=%b p_data=%h required 0/00", cnt_en, p_data);
        end
    endtask

    task automatic test_cfg_toggle();
        @(negedge clk);
        exp_q.push_back(8'h3C);
        fork
            send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1);
            begin
                repeat (40) @(negedge clk);
                par_en  = 1'b0;
                par_typ = 1'b1;
            end
        join
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0 || p_data !== 8'h3C) begin
            bad++;
            $display("FAIL cfg_toggle_data: pending=%0d p_data=%h required 0/3c", exp_q.size(), p_data);
        end
        total++;
        if ({par_err, stp_err} !== 2'b00) begin
            bad++;
            $display("FAIL cfg_toggle_errs: %b required 00", {par_err, stp_err});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_glitch();
        test_stop_err();
        test_back_to_back();
        test_reset_mid();
        test_cfg_toggle();
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
